// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin arbiter sharing one binary-to-BCD converter among N_REQ
// requesters. Sequences the converter start/done handshake, aborts with an error after
// TIMEOUT cycles without completion, and returns the result with a one-cycle ack.
// Optional feature: define BCD_ARB_CLAMP_EN to clamp operands above 999999 and flag them
// through rsp_err.
module bcd_conv_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned IDW    = $clog2(N_REQ)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*20-1:0]   req_data,
    output logic [N_REQ-1:0]      ack,
    output logic [23:0]           rsp_bcd,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_err,
    output logic                  cv_start,
    output logic [19:0]           cv_data,
    input  logic                  cv_done,
    input  logic [23:0]           cv_bcd
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] LastId = IDW'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

    state_e state_q, state_d;

    logic [N_REQ-1:0] ack_q, ack_d;
    logic [23:0]      rsp_bcd_q, rsp_bcd_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;
    logic             cv_start_q, cv_start_d;
    logic [19:0]      cv_data_q, cv_data_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]    timer_q, timer_d;
    // Remembers that the current operand was clamped, so the ack reports it as an error.
    logic             clamp_q, clamp_d;

    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     scan;
    logic [19:0]      grant_op;
    logic             timeout_hit;

    // Round-robin scan: first set request starting at ptr_q, wrapping modulo N_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(i);
            if (scan >= (IDW+1)'(N_REQ)) begin
                scan = scan - (IDW+1)'(N_REQ);
            end
            if (!grant_vld && req[scan[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan[IDW-1:0];
            end
        end
    end

    // Operand of the winning requester, clamped when the option is built in.
    always_comb begin
        grant_op = req_data[32'(grant_idx) * 20 +: 20];
        clamp_d  = clamp_q;
        if (state_q == StIdle && grant_vld) begin
`ifdef BCD_ARB_CLAMP_EN
            clamp_d = (grant_op > 20'hF423F);
            if (grant_op > 20'hF423F) begin
                grant_op = 20'hF423F;
            end
`else
            clamp_d = 1'b0;
`endif
        end
    end

    assign timeout_hit = (timer_q == TimerMax);

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cv_done takes precedence over timer expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_vld) state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (cv_done || timeout_hit) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs and datapath, computed one cycle ahead of the state they belong to.
    always_comb begin
        ack_d      = '0;
        cv_start_d = 1'b0;
        rsp_bcd_d  = rsp_bcd_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        cv_data_d  = cv_data_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    rsp_id_d   = grant_idx;
                    cv_data_d  = grant_op;
                    cv_start_d = 1'b1;
                end
            end
            StStart: begin
                timer_d = '0;
            end
            StWait: begin
                if (cv_done) begin
                    rsp_bcd_d       = cv_bcd;
                    rsp_err_d       = clamp_q;
                    ack_d[rsp_id_q] = 1'b1;
                end else if (timeout_hit) begin
                    rsp_bcd_d       = 24'h0;
                    rsp_err_d       = 1'b1;
                    ack_d[rsp_id_q] = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StResp: begin
                ptr_d = (rsp_id_q == LastId) ? '0 : rsp_id_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ack_q      <= '0;
            rsp_bcd_q  <= '0;
            rsp_id_q   <= '0;
            rsp_err_q  <= 1'b0;
            cv_start_q <= 1'b0;
            cv_data_q  <= '0;
            ptr_q      <= '0;
            timer_q    <= '0;
            clamp_q    <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            rsp_bcd_q  <= rsp_bcd_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
            cv_start_q <= cv_start_d;
            cv_data_q  <= cv_data_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            clamp_q    <= clamp_d;
        end
    end

    assign ack      = ack_q;
    assign rsp_bcd  = rsp_bcd_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_err  = rsp_err_q;
    assign cv_start = cv_start_q;
    assign cv_data  = cv_data_q;

endmodule
